// File: rtl/edib_m5m7_tx.sv
// Manchester frame transmitter for the EDIB M5/M7 telemetry line: sync, WIDTH data bits
// (MSB first) and odd parity, paced by edges of the sampled clk_m5m7 bit clock.
module edib_m5m7_tx #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned GAP_BITS = 2,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic             clk_12m,
    input  logic             reset,
    input  logic             clk_m5m7,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_cmd,
    input  logic             tx_start,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             m5m7_out,
    output logic             m5m7_oe
);
    localparam int unsigned SYNC_HALVES = 6;
    localparam int unsigned HALVES      = 2 * (WIDTH + 4);
    localparam int unsigned GAP_TICKS   = 2 * GAP_BITS;
    localparam int unsigned IW          = $clog2(HALVES);
    localparam int unsigned GW          = $clog2(GAP_TICKS + 1);

    typedef enum logic [2:0] {IDLE, ALIGN, SYNC, DATA, GAP} state_t;

    state_t         state_q, state_d;
    logic           clk_q;
    logic [IW-1:0]  idx_q, idx_d, idx_nxt;
    logic [GW-1:0]  gcnt_q, gcnt_d;
    logic [WIDTH:0] frame_q, frame_d;
    logic           cmd_q, cmd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           out_q, out_d;
    logic           oe_q, oe_d;
    logic           tick, rise;

    // Line level for frame half-bit idx: sync halves first, then {data, parity} Manchester pairs.
    function automatic logic half_val(input logic [IW-1:0] idx, input logic cmd,
                                      input logic [WIDTH:0] frame);
        int unsigned    k;
        logic [WIDTH:0] sh;
        k = 32'(idx);
        if (k < SYNC_HALVES) return (k < SYNC_HALVES / 2) == cmd;
        k  = k - SYNC_HALVES;
        sh = frame << (k >> 1);
        return sh[WIDTH] ^ k[0];
    endfunction

    assign tick    = clk_m5m7 ^ clk_q;
    assign rise    = clk_m5m7 & ~clk_q;
    assign idx_nxt = idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        frame_d = frame_q;
        cmd_d   = cmd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        oe_d    = oe_q;
        unique case (state_q)
            IDLE: begin
                // Holding off while done_q is high keeps a request in the tx_done cycle ignored.
                if (tx_start && !done_q) begin
                    frame_d = {tx_data, ~^tx_data};
                    cmd_d   = tx_cmd;
                    busy_d  = 1'b1;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (rise) begin
                    oe_d    = 1'b1;
                    out_d   = half_val('0, cmd_q, frame_q);
                    idx_d   = '0;
                    state_d = SYNC;
                end
            end
            SYNC, DATA: begin
                if (tick) begin
                    if (idx_q == IW'(HALVES - 1)) begin
                        oe_d    = 1'b0;
                        out_d   = IDLE_LVL;
                        gcnt_d  = '0;
                        state_d = GAP;
                    end else begin
                        idx_d   = idx_nxt;
                        out_d   = half_val(idx_nxt, cmd_q, frame_q);
                        state_d = (32'(idx_nxt) >= SYNC_HALVES) ? DATA : SYNC;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gcnt_q == GW'(GAP_TICKS - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        gcnt_d = gcnt_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_12m or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            clk_q   <= 1'b0;
            idx_q   <= '0;
            gcnt_q  <= '0;
            frame_q <= '0;
            cmd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= IDLE_LVL;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_m5m7;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            frame_q <= frame_d;
            cmd_q   <= cmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
        end
    end

    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign m5m7_out = out_q;
    assign m5m7_oe  = oe_q;

endmodule
